// File: rtl/qbus_console_pkg.sv
// qbus_console_pkg: shared definitions for the Q-bus console port.
//  - register word offsets inside the 8-byte window (selected by addr[2:1])
//  - CSR bit positions
//  - bus-cycle FSM state encoding
//  - csr_word(): builds a CSR read word from its status and IE bits
// The optional interrupt feature is selected with the CONSOLE_IRQ_EN macro.
package qbus_console_pkg;

   localparam logic [1:0] REG_RCSR = 2'd0;   // BASE+0
   localparam logic [1:0] REG_RBUF = 2'd1;   // BASE+2
   localparam logic [1:0] REG_XCSR = 2'd2;   // BASE+4
   localparam logic [1:0] REG_XBUF = 2'd3;   // BASE+6

   localparam int CSR_DONE  = 7;   // RCSR: receive buffer full
   localparam int CSR_READY = 7;   // XCSR: transmit FIFO has room
   localparam int CSR_IE    = 6;   // interrupt enable in both CSRs

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_RD   = 3'd2,
      ST_WR   = 3'd3,
      ST_WAIT = 3'd4
   } state_t;

   function automatic logic [15:0] csr_word(input logic status, input logic ie);
      logic [15:0] w;
      w = '0;
      w[CSR_DONE] = status;
      w[CSR_IE]   = ie;
      return w;
   endfunction

endpackage

// File: rtl/qbus_console_if.sv
// qbus_console_if: multiplexed, active-low Q-bus signals seen by the console port.
//  ad_n    16  address/data (tri-state, terminated high)
//  sync_n   1  address strobe
//  din_n    1  read data strobe
//  dout_n   1  write data strobe
//  wtbt_n   1  byte-write qualifier during dout_n
//  rply_n   1  open-drain reply (terminated high)
// Modports: master (CPU side), slave (console port).
interface qbus_console_if;

   // The backplane terminators hold undriven lines at the inactive (high) level.
   tri1 [15:0] ad_n;
   tri1        rply_n;
   logic       sync_n;
   logic       din_n;
   logic       dout_n;
   logic       wtbt_n;

   modport master (inout ad_n, output sync_n, output din_n, output dout_n,
                   output wtbt_n, input rply_n);
   modport slave  (inout ad_n, input sync_n, input din_n, input dout_n,
                   input wtbt_n, output rply_n);

endinterface

// File: rtl/qbus_console_fifo.sv
// qbus_console_fifo: synchronous FIFO for the console transmit byte stream.
// Ports:
//  clk, rst   clock, asynchronous active-high reset (pointers only)
//  push, din  write request and data; accepted when not full, or when full
//             and a pop happens in the same cycle
//  pop        read request; ignored when empty
//  head       oldest entry, 0 while empty
//  full/empty status from pointer compare
module qbus_console_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty when the indices match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok  = pop & ~empty;
   // On a full FIFO a same-cycle pop frees the slot the push writes into.
   assign push_ok = push & (~full | pop_ok);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/qbus_console.sv
// qbus_console: DL11-style console port as a Q-bus slave for the 1801VM1 system.
// Registers in an 8-byte window at BASE: RCSR, RBUF, XCSR, XBUF.
// Ports:
//  clk, rst             system clock, asynchronous active-high reset
//  bus (slave modport)  ad_n / sync_n / din_n / dout_n / wtbt_n / rply_n
//  tx_data, tx_valid    head of the transmit FIFO toward the host
//  tx_ready             host pops the head when tx_valid & tx_ready
//  rx_data, rx_valid    byte offered by the host
//  rx_ready             receive buffer empty; byte taken when rx_valid & rx_ready
//  irq_n                active-low interrupt request
// Build option: CONSOLE_IRQ_EN makes the IE bits writable and drives irq_n;
// without it IE reads 0 and irq_n stays high.
module qbus_console
   import qbus_console_pkg::*;
#(
   parameter logic [15:0] BASE     = 16'o177560,
   parameter int          TX_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   qbus_console_if.slave        bus,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   output logic                 irq_n
);

   state_t      state;
   logic        sync_prev;
   logic [2:0]  addr_q;
   logic        rply_on;
   logic        ad_en;
   logic [15:0] ad_out;

   logic        rx_full;
   logic [7:0]  rx_byte;
   logic        tx_full;
   logic        tx_empty;
   logic        rie;
   logic        xie;

   logic        sync_fall;
   logic        sync_rise;
   logic        in_window;
   logic        start_rd;
   logic        start_wr;
   logic        rbuf_done;
   logic        byte_hi;
   logic        push;
   logic [15:0] wdata;
   logic [7:0]  wbyte;
   logic [15:0] rdata;

   assign sync_fall = sync_prev & ~bus.sync_n;
   assign sync_rise = ~sync_prev & bus.sync_n;
   assign in_window = ((~bus.ad_n[15:3]) == BASE[15:3]);

   // A new data strobe may start from ADDR or, for read-modify-write, from WAIT.
   assign start_rd  = (state == ST_ADDR || state == ST_WAIT) && !bus.sync_n && !bus.din_n;
   assign start_wr  = (state == ST_ADDR || state == ST_WAIT) && !bus.sync_n && !bus.dout_n
                      && bus.din_n;
   // DONE is cleared only once the CPU has finished taking the RBUF data.
   assign rbuf_done = (state == ST_RD) && bus.din_n && (addr_q[2:1] == REG_RBUF);

   assign wdata   = ~bus.ad_n;
   assign byte_hi = ~bus.wtbt_n & addr_q[0];
   assign wbyte   = byte_hi ? wdata[15:8] : wdata[7:0];
   assign push    = start_wr && (addr_q[2:1] == REG_XBUF);

   always_comb begin
      rdata = '0;
      case (addr_q[2:1])
         REG_RCSR: rdata = csr_word(rx_full, rie);
         REG_RBUF: rdata = {8'h00, rx_byte};
         REG_XCSR: rdata = csr_word(~tx_full, xie);
         default:  rdata = '0;
      endcase
   end

   assign bus.ad_n   = ad_en ? ad_out : 16'hzzzz;
   assign bus.rply_n = rply_on ? 1'b0 : 1'bz;

   // Bus-cycle FSM; reply and data drive are registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         sync_prev <= 1'b1;
         addr_q    <= '0;
         rply_on   <= 1'b0;
         ad_en     <= 1'b0;
         ad_out    <= '0;
      end else begin
         sync_prev <= bus.sync_n;
         if (sync_rise) begin
            state   <= ST_IDLE;
            rply_on <= 1'b0;
            ad_en   <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (sync_fall && in_window) begin
                     state  <= ST_ADDR;
                     addr_q <= ~bus.ad_n[2:0];
                  end
               end
               ST_ADDR, ST_WAIT: begin
                  if (start_rd) begin
                     state  <= ST_RD;
                     ad_en  <= 1'b1;
                     ad_out <= ~rdata;
                  end else if (start_wr) begin
                     state <= ST_WR;
                  end else if (bus.sync_n) begin
                     state <= ST_IDLE;
                  end
               end
               ST_RD: begin
                  if (bus.din_n) begin
                     state   <= ST_WAIT;
                     rply_on <= 1'b0;
                     ad_en   <= 1'b0;
                  end else begin
                     rply_on <= 1'b1;
                  end
               end
               ST_WR: begin
                  if (bus.dout_n) begin
                     state   <= ST_WAIT;
                     rply_on <= 1'b0;
                  end else begin
                     rply_on <= 1'b1;
                  end
               end
               default: begin
                  state   <= ST_IDLE;
                  rply_on <= 1'b0;
                  ad_en   <= 1'b0;
               end
            endcase
         end
      end
   end

   // Receive buffer: a clear in the same cycle as an offer wins; rx_ready is
   // low then, so the offered byte is taken on the following cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_full <= 1'b0;
      end else if (rbuf_done) begin
         rx_full <= 1'b0;
      end else if (rx_valid && !rx_full) begin
         rx_full <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_valid && !rx_full && !rbuf_done) rx_byte <= rx_data;
   end

   assign rx_ready = ~rx_full;

   qbus_console_fifo #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (wbyte),
      .pop   (tx_ready),
      .head  (tx_data),
      .full  (tx_full),
      .empty (tx_empty)
   );

   assign tx_valid = ~tx_empty;

`ifdef CONSOLE_IRQ_EN
   logic irq_q;
   logic csr_wr;

   // A high-byte-only write never touches the IE bits in the low byte.
   assign csr_wr = start_wr & ~byte_hi;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rie   <= 1'b0;
         xie   <= 1'b0;
         irq_q <= 1'b1;
      end else begin
         if (csr_wr && addr_q[2:1] == REG_RCSR) rie <= wdata[CSR_IE];
         if (csr_wr && addr_q[2:1] == REG_XCSR) xie <= wdata[CSR_IE];
         irq_q <= ~((rie & rx_full) | (xie & ~tx_full));
      end
   end

   assign irq_n = irq_q;
`else
   assign rie   = 1'b0;
   assign xie   = 1'b0;
   assign irq_n = 1'b1;
`endif

endmodule

// File: tb/tb_qbus_console.sv
// tb_qbus_console: directed, table-driven bench for qbus_console.
module tb_qbus_console;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       irq_n;

   logic        m_en;
   logic [15:0] m_val;

   int errors;
   int checks;

   qbus_console_if bus ();

   assign bus.ad_n = m_en ? m_val : 16'hzzzz;

   qbus_console dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .irq_n    (irq_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {OP_RD, OP_WR, OP_WB, OP_POP, OP_TXV, OP_RX, OP_RXRDY} op_t;

   typedef struct {
      op_t         op;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] exp;
      bit          exp_rply;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %o, expected %o", name, got, exp);
      end
   endtask

   // Full read cycle; lat counts clocks from din_n fall to rply_n seen low.
   task automatic bus_read(input logic [15:0] addr, output logic [15:0] data,
                           output bit replied, output int lat, output bit rel,
                           output bit ad_idle);
      @(negedge clk);
      m_val = ~addr; m_en = 1'b1; bus.sync_n = 1'b0;
      @(negedge clk);
      m_en = 1'b0; bus.din_n = 1'b0;
      replied = 1'b0; lat = 0; data = '0; ad_idle = 1'b1;
      for (int i = 1; i <= 8 && !replied; i++) begin
         @(negedge clk);
         if (bus.rply_n === 1'b0) begin
            replied = 1'b1; lat = i; data = ~bus.ad_n;
         end else if (bus.ad_n !== 16'hFFFF) begin
            ad_idle = 1'b0;
         end
      end
      bus.din_n = 1'b1;
      @(negedge clk);
      rel = (bus.rply_n === 1'b1) && (bus.ad_n === 16'hFFFF);
      bus.sync_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [15:0] data,
                            input bit bw, input bit pop, output bit replied, output int lat);
      @(negedge clk);
      m_val = ~addr; m_en = 1'b1; bus.sync_n = 1'b0;
      @(negedge clk);
      m_val = ~data; bus.wtbt_n = ~bw; bus.dout_n = 1'b0; tx_ready = pop;
      replied = 1'b0; lat = 0;
      for (int i = 1; i <= 8 && !replied; i++) begin
         @(negedge clk);
         tx_ready = 1'b0;
         if (bus.rply_n === 1'b0) begin
            replied = 1'b1; lat = i;
         end
      end
      bus.dout_n = 1'b1; bus.wtbt_n = 1'b1; m_en = 1'b0;
      @(negedge clk);
      bus.sync_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pop_one();
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
   endtask

   task automatic add(input op_t op, input logic [15:0] addr, input logic [15:0] data,
                      input logic [15:0] exp, input bit rp, input string name);
      vec_t v;
      v.op = op; v.addr = addr; v.data = data; v.exp = exp; v.exp_rply = rp; v.name = name;
      vecs.push_back(v);
   endtask

   logic [15:0] rd;
   bit          rep;
   bit          rel;
   bit          idle;
   int          lat;

   initial begin
      errors = 0; checks = 0;
      rst = 1'b1; m_en = 1'b0; m_val = '0;
      bus.sync_n = 1'b1; bus.din_n = 1'b1; bus.dout_n = 1'b1; bus.wtbt_n = 1'b1;
      tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

      add(OP_RD,    16'o177564, 0, 16'o000200, 1, "xcsr_reset");
      add(OP_RD,    16'o177560, 0, 16'o000000, 1, "rcsr_reset");
      add(OP_RD,    16'o177566, 0, 16'o000000, 1, "xbuf_read");
      for (int i = 0; i < 4; i++) add(OP_WR, 16'o177566, 16'o000101, 0, 1, "xbuf_wr");
      add(OP_RD,    16'o177564, 0, 16'o000000, 1, "xcsr_full");
      add(OP_WR,    16'o177566, 16'o000102, 0, 1, "xbuf_drop");
      add(OP_TXV,   0, 0, 16'd1, 0, "txv_full");
      for (int i = 0; i < 4; i++) add(OP_POP, 0, 0, 16'h0041, 0, "pop_101");
      add(OP_TXV,   0, 0, 16'd0, 0, "txv_drained");
      add(OP_RD,    16'o177564, 0, 16'o000200, 1, "xcsr_ready");
      add(OP_RD,    16'o177570, 0, 0, 0, "miss_177570");
      add(OP_RD,    16'o177550, 0, 0, 0, "miss_177550");
      add(OP_WB,    16'o177567, 16'h4100, 0, 1, "bw_hi");
      add(OP_POP,   0, 0, 16'h0041, 0, "pop_bw_hi");
      add(OP_WB,    16'o177566, 16'h2233, 0, 1, "bw_lo");
      add(OP_POP,   0, 0, 16'h0033, 0, "pop_bw_lo");
      add(OP_WR,    16'o177567, 16'h1234, 0, 1, "word_odd");
      add(OP_POP,   0, 0, 16'h0034, 0, "pop_word_odd");
      add(OP_TXV,   0, 0, 16'd0, 0, "txv_empty");
      add(OP_RXRDY, 0, 0, 16'd1, 0, "rxrdy_idle");
      add(OP_RX,    0, 16'h005A, 0, 0, "rx_5a");
      add(OP_RXRDY, 0, 0, 16'd0, 0, "rxrdy_full");
      add(OP_RD,    16'o177560, 0, 16'o000200, 1, "rcsr_done");
      add(OP_RD,    16'o177562, 0, 16'o000132, 1, "rbuf_5a");
      add(OP_RD,    16'o177560, 0, 16'o000000, 1, "rcsr_clear");
      add(OP_RXRDY, 0, 0, 16'd1, 0, "rxrdy_again");

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data",  tx_data, 0);
      chk("rst_rx_ready", rx_ready, 1);
      chk("rst_irq_n",    irq_n, 1);
      chk("rst_rply_n",   bus.rply_n, 1);
      chk("rst_ad_n",     bus.ad_n, 16'hFFFF);

      foreach (vecs[i]) begin
         case (vecs[i].op)
            OP_RD: begin
               bus_read(vecs[i].addr, rd, rep, lat, rel, idle);
               chk({vecs[i].name, "_rply"}, rep, vecs[i].exp_rply);
               if (vecs[i].exp_rply) begin
                  chk({vecs[i].name, "_data"}, rd, vecs[i].exp);
                  chk({vecs[i].name, "_lat"}, lat, 2);
                  chk({vecs[i].name, "_rel"}, rel, 1);
               end else begin
                  chk({vecs[i].name, "_ad_z"}, idle, 1);
               end
            end
            OP_WR, OP_WB: begin
               bus_write(vecs[i].addr, vecs[i].data, vecs[i].op == OP_WB, 1'b0, rep, lat);
               chk({vecs[i].name, "_rply"}, rep, 1);
            end
            OP_POP: begin
               chk({vecs[i].name, "_valid"}, tx_valid, 1);
               chk({vecs[i].name, "_data"}, tx_data, vecs[i].exp);
               pop_one();
            end
            OP_TXV:   chk(vecs[i].name, tx_valid, vecs[i].exp);
            OP_RXRDY: chk(vecs[i].name, rx_ready, vecs[i].exp);
            OP_RX: begin
               chk({vecs[i].name, "_ready"}, rx_ready, 1);
               rx_data = vecs[i].data[7:0]; rx_valid = 1'b1;
               @(negedge clk);
               rx_valid = 1'b0;
            end
            default: ;
         endcase
      end

      // Push into a full FIFO in the same cycle as a pop: both take effect.
      for (int i = 1; i <= 4; i++) bus_write(16'o177566, 16'(i), 1'b0, 1'b0, rep, lat);
      bus_write(16'o177566, 16'h0005, 1'b0, 1'b1, rep, lat);
      chk("fullpp_rply", rep, 1);
      for (int i = 2; i <= 5; i++) begin
         chk("fullpp_data", tx_data, 16'(i));
         pop_one();
      end
      chk("fullpp_empty", tx_valid, 0);

      // DONE holds through the RBUF read and clears at din_n rise; a byte
      // offered during the read is taken the cycle after the clear.
      rx_data = 8'h11; rx_valid = 1'b1;
      @(negedge clk);
      rx_data = 8'hA5;
      chk("rx11_taken", rx_ready, 0);
      @(negedge clk);
      m_val = ~16'o177562; m_en = 1'b1; bus.sync_n = 1'b0;
      @(negedge clk);
      m_en = 1'b0; bus.din_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rbuf11_rply", bus.rply_n, 0);
      chk("rbuf11_data", ~bus.ad_n, 16'h0011);
      chk("done_held_mid_read", rx_ready, 0);
      bus.din_n = 1'b1;
      @(negedge clk);
      chk("done_clr_on_rise", rx_ready, 1);
      @(negedge clk);
      chk("rx_a5_next_cycle", rx_ready, 0);
      rx_valid = 1'b0; bus.sync_n = 1'b1;
      @(negedge clk);
      bus_read(16'o177562, rd, rep, lat, rel, idle);
      chk("rbuf_a5", rd, 16'h00A5);
      bus_read(16'o177560, rd, rep, lat, rel, idle);
      chk("rcsr_after_a5", rd, 16'o000000);

`ifdef CONSOLE_IRQ_EN
      bus_write(16'o177564, 16'o000100, 1'b0, 1'b0, rep, lat);
      chk("irq_xie_on", irq_n, 0);
      bus_read(16'o177564, rd, rep, lat, rel, idle);
      chk("xcsr_ie_rd", rd, 16'o000300);
      for (int i = 0; i < 4; i++) bus_write(16'o177566, 16'h0020, 1'b0, 1'b0, rep, lat);
      chk("irq_fifo_full", irq_n, 1);
      for (int i = 0; i < 4; i++) pop_one();
      @(negedge clk);
      chk("irq_fifo_drained", irq_n, 0);
      bus_write(16'o177564, 16'o000000, 1'b0, 1'b0, rep, lat);
      chk("irq_xie_off", irq_n, 1);
`else
      bus_write(16'o177564, 16'o000100, 1'b0, 1'b0, rep, lat);
      bus_read(16'o177564, rd, rep, lat, rel, idle);
      chk("xcsr_ie_ignored", rd, 16'o000200);
      chk("irq_tied_high", irq_n, 1);
`endif

      // Asynchronous reset in the middle of a read reply.
      bus_write(16'o177566, 16'h0077, 1'b0, 1'b0, rep, lat);
      rx_data = 8'h33; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      m_val = ~16'o177564; m_en = 1'b1; bus.sync_n = 1'b0;
      @(negedge clk);
      m_en = 1'b0; bus.din_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrd_rply", bus.rply_n, 0);
      #2 rst = 1'b1;
      #1;
      chk("midrd_rst_rply", bus.rply_n, 1);
      chk("midrd_rst_ad",   bus.ad_n, 16'hFFFF);
      chk("midrd_rst_txv",  tx_valid, 0);
      chk("midrd_rst_txd",  tx_data, 0);
      chk("midrd_rst_rxr",  rx_ready, 1);
      chk("midrd_rst_irq",  irq_n, 1);
      @(negedge clk);
      bus.din_n = 1'b1; bus.sync_n = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      bus_read(16'o177564, rd, rep, lat, rel, idle);
      chk("post_rst_rply", rep, 1);
      chk("post_rst_xcsr", rd, 16'o000200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop in case a bus task never returns.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
